// File: rtl/spi_slv_pkg.sv
// Shared types and constants for the SPI slave frame front end.
package spi_slv_pkg;

    localparam int CMD_W = 2;

    localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
    localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        DONE,
        WAIT_TX,
        SEND
    } spi_slv_state_t;

endpackage

// File: rtl/spi_slv_shifter.sv
// Serial-in/parallel-out frame register and parallel-load/serial-out reply register sharing one
// saturating bit counter; rx_next_o is the frame value including the bit on mosi_i this cycle.
module spi_slv_shifter #(
    parameter int  WORD_W    = 8,
    parameter bit  MSB_FIRST = 1'b1,
    localparam int FRAME_W   = WORD_W + 2,
    localparam int CNT_W     = $clog2(FRAME_W + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               rx_shift_i,
    input  logic               mosi_i,
    input  logic               tx_load_i,
    input  logic [WORD_W-1:0]  tx_data_i,
    input  logic               tx_shift_i,
    output logic [FRAME_W-1:0] rx_next_o,
    output logic [CNT_W-1:0]   bit_cnt_o,
    output logic               tx_bit_o
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FRAME_W);

    logic [FRAME_W-1:0] rx_q, rx_d;
    logic [WORD_W-1:0]  tx_q, tx_d, tx_shifted;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    generate
        if (MSB_FIRST) begin : g_msb
            assign rx_next_o  = {rx_q[FRAME_W-2:0], mosi_i};
            assign tx_shifted = {tx_q[WORD_W-2:0], 1'b0};
            assign tx_bit_o   = tx_q[WORD_W-1];
        end else begin : g_lsb
            assign rx_next_o  = {mosi_i, rx_q[FRAME_W-1:1]};
            assign tx_shifted = {1'b0, tx_q[WORD_W-1:1]};
            assign tx_bit_o   = tx_q[0];
        end
    endgenerate

    assign bit_cnt_o = cnt_q;

    always_comb begin
        rx_d  = rx_q;
        tx_d  = tx_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            rx_d  = '0;
            tx_d  = '0;
            cnt_d = '0;
        end else begin
            if (rx_shift_i) begin
                rx_d = rx_next_o;
            end
            if (tx_load_i) begin
                tx_d  = tx_data_i;
                cnt_d = '0;
            end else begin
                if (tx_shift_i) begin
                    tx_d = tx_shifted;
                end
                // Counter parks at the frame width instead of wrapping.
                if ((rx_shift_i || tx_shift_i) && (cnt_q != CNT_SAT)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_q  <= '0;
            tx_q  <= '0;
            cnt_q <= '0;
        end else begin
            rx_q  <= rx_d;
            tx_q  <= tx_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_slave_frame_if.sv
// SPI slave: frames delivered the cycle after their last bit, read replies serialised one cycle after
// tx_valid; ss_n high aborts. Define SPI_SLV_ABORT_EN to add the frame_abort pulse output.
module spi_slave_frame_if
    import spi_slv_pkg::*;
#(
    parameter int  WORD_W    = 8,
    parameter bit  MSB_FIRST = 1'b1,
    localparam int FRAME_W   = WORD_W + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ss_n,
    input  logic               MOSI,
    input  logic               tx_valid,
    input  logic [WORD_W-1:0]  tx_data,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    output logic               tx_ready,
    output logic               MISO
`ifdef SPI_SLV_ABORT_EN
    ,
    output logic               frame_abort
`endif
);

    localparam int               CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(WORD_W - 1);

    spi_slv_state_t     state_q, state_d;
    logic               rd_seen_q, rd_seen_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;

    logic               clr, rx_shift, tx_load, tx_shift, tx_bit;
    logic [FRAME_W-1:0] rx_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CMD_W-1:0]   cmd;

`ifdef SPI_SLV_ABORT_EN
    logic abort_pend_q, abort_pend_d, frame_abort_q;
`endif

    spi_slv_shifter #(
        .WORD_W   (WORD_W),
        .MSB_FIRST(MSB_FIRST)
    ) u_shifter (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (clr),
        .rx_shift_i(rx_shift),
        .mosi_i    (MOSI),
        .tx_load_i (tx_load),
        .tx_data_i (tx_data),
        .tx_shift_i(tx_shift),
        .rx_next_o (rx_next),
        .bit_cnt_o (bit_cnt),
        .tx_bit_o  (tx_bit)
    );

    assign cmd = rx_next[FRAME_W-1 -: CMD_W];

    always_comb begin
        state_d    = state_q;
        rd_seen_d  = rd_seen_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        clr        = ss_n;
        rx_shift   = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
`ifdef SPI_SLV_ABORT_EN
        abort_pend_d = 1'b0;
`endif
        if (ss_n) begin
            // ss_n wins over any bit due this cycle, including the last frame bit.
            state_d = IDLE;
            if (state_q == SEND) begin
                rd_seen_d = 1'b0;
            end
`ifdef SPI_SLV_ABORT_EN
            if (state_q inside {RECV, WAIT_TX, SEND}) begin
                abort_pend_d = 1'b1;
            end
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    rx_shift = 1'b1;
                    state_d  = RECV;
                end
                RECV: begin
                    rx_shift = 1'b1;
                    if (bit_cnt == LAST_RX) begin
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        state_d    = DONE;
                        case (cmd)
                            CMD_RD_ADDR: rd_seen_d = 1'b1;
                            CMD_RD_DATA: begin
                                if (rd_seen_q) begin
                                    state_d = WAIT_TX;
                                end
`ifdef SPI_SLV_ABORT_EN
                                else begin
                                    abort_pend_d = 1'b1;
                                end
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                DONE: ;
                WAIT_TX: begin
                    if (tx_valid) begin
                        tx_load = 1'b1;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (bit_cnt == LAST_TX) begin
                        state_d   = DONE;
                        rd_seen_d = 1'b0;
                    end else begin
                        tx_shift = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_seen_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_seen_q  <= rd_seen_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

`ifdef SPI_SLV_ABORT_EN
    // Two-stage so the pulse lands one cycle after IDLE is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            abort_pend_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            abort_pend_q  <= abort_pend_d;
            frame_abort_q <= abort_pend_q;
        end
    end

    assign frame_abort = frame_abort_q;
`endif

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_ready = (state_q == WAIT_TX);
    assign MISO     = (state_q == SEND) && tx_bit;

endmodule

// File: tb/tb_spi_slave_frame_if.sv
// Bench for spi_slave_frame_if: directed and random transactions against a transaction-level model.
module tb_spi_slave_frame_if;

    localparam int WORD_W  = 8;
    localparam int FRAME_W = WORD_W + 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               ss_n;
    logic               MOSI;
    logic               tx_valid;
    logic [WORD_W-1:0]  tx_data;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic               tx_ready;
    logic               MISO;
`ifdef SPI_SLV_ABORT_EN
    logic               frame_abort;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [FRAME_W-1:0] m_rx;
    bit                 m_rd_seen;

    always #5 clk = ~clk;

    spi_slave_frame_if #(
        .WORD_W   (WORD_W),
        .MSB_FIRST(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ss_n       (ss_n),
        .MOSI       (MOSI),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_ready   (tx_ready),
        .MISO       (MISO)
`ifdef SPI_SLV_ABORT_EN
        ,
        .frame_abort(frame_abort)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One transaction; cycle 0 is the first cycle with ss_n low.
    // nb: bits clocked before ss_n rises (FRAME_W = complete frame).
    // wait_c: cycles in WAIT_TX before tx_valid. cut: -1 abort in WAIT_TX, 0..WORD_W-1 abort
    // while reply bit 'cut' is on MISO, WORD_W = full reply. rst_cyc >= 0 asserts rst in that cycle.
    task automatic txn(input logic [FRAME_W-1:0] frame, input int nb, input int wait_c, input int cut,
                       input logic [WORD_W-1:0] data, input int done_d, input int gap, input int rst_cyc);
        bit full, reply, proto, after_rst;
        int t, ss_rise, tr_end, miso_end, ab_cyc, end_c;
        logic [FRAME_W-1:0] old_rx, e_rd;
        logic [1:0] cmd;
        logic e_rv, e_tr, e_miso, e_ab;

        cmd      = frame[FRAME_W-1 -: 2];
        full     = (nb >= FRAME_W);
        reply    = full && (cmd == 2'b11) && m_rd_seen;
        proto    = full && (cmd == 2'b11) && !m_rd_seen;
        old_rx   = m_rx;
        t        = -100;
        tr_end   = -100;
        miso_end = -100;
        ab_cyc   = -100;

        if (!full) begin
            ss_rise = nb;
            ab_cyc  = nb + 2;
        end else if (!reply) begin
            ss_rise = FRAME_W + done_d;
            if (proto) ab_cyc = FRAME_W + 1;
        end else if (cut < 0) begin
            ss_rise = FRAME_W + wait_c;
            tr_end  = ss_rise;
            ab_cyc  = ss_rise + 2;
        end else begin
            t      = FRAME_W + wait_c;
            tr_end = t;
            if (cut < WORD_W) begin
                ss_rise  = t + 1 + cut;
                miso_end = ss_rise;
                ab_cyc   = ss_rise + 2;
            end else begin
                ss_rise  = t + WORD_W + 1 + done_d;
                miso_end = t + WORD_W;
            end
        end
        if (rst_cyc >= 0) ss_rise = rst_cyc + 1;
        end_c = ss_rise + gap - 1;

        for (int c = 0; c <= end_c; c++) begin
            after_rst = (rst_cyc >= 0) && (c > rst_cyc);
            e_rv   = !after_rst && full && (c == FRAME_W);
            e_rd   = after_rst ? '0 : ((full && c >= FRAME_W) ? frame : old_rx);
            e_tr   = !after_rst && reply && (c >= FRAME_W) && (c <= tr_end);
            e_miso = 1'b0;
            if (!after_rst && reply && (c >= t + 1) && (c <= miso_end))
                e_miso = data[WORD_W-1-(c-t-1)];
            e_ab   = !after_rst && (c == ab_cyc);

            @(negedge clk);
            check_val("rx_valid", rx_valid, e_rv);
            check_val("rx_data", rx_data, e_rd);
            check_val("tx_ready", tx_ready, e_tr);
            check_val("MISO", MISO, e_miso);
`ifdef SPI_SLV_ABORT_EN
            check_val("frame_abort", frame_abort, e_ab);
`endif
            rst  = (c == rst_cyc);
            ss_n = (c >= ss_rise);
            MOSI = (c < FRAME_W) ? frame[FRAME_W-1-c] : 1'($urandom_range(0, 1));
            if (reply && (c >= FRAME_W) && (c <= tr_end))
                tx_valid = (c == t);
            else
                tx_valid = 1'($urandom_range(0, 1));
            tx_data = (c == t) ? data : WORD_W'($urandom);
        end
        rst = 1'b0;

        if (rst_cyc >= 0) begin
            m_rx      = '0;
            m_rd_seen = 1'b0;
        end else begin
            if (full) m_rx = frame;
            if (full && cmd == 2'b10) m_rd_seen = 1'b1;
            if (reply && cut >= 0) m_rd_seen = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        ss_n      = 1'b1;
        MOSI      = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        m_rx      = '0;
        m_rd_seen = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_rx_data", rx_data, 0);
        check_val("rst_rx_valid", rx_valid, 0);
        check_val("rst_tx_ready", tx_ready, 0);
        check_val("rst_MISO", MISO, 0);
`ifdef SPI_SLV_ABORT_EN
        check_val("rst_frame_abort", frame_abort, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        txn(10'h0A5, FRAME_W, 0, WORD_W, 8'h00, 1, 3, -1);
        txn(10'h13C, FRAME_W, 0, WORD_W, 8'h00, 0, 3, -1);
        txn(10'h255, FRAME_W, 0, WORD_W, 8'h00, 2, 3, -1);
        txn(10'h300, FRAME_W, 2, WORD_W, 8'hC3, 1, 3, -1);
        txn(10'h3FF, FRAME_W, 0, WORD_W, 8'h00, 2, 3, -1);
        txn(10'h1AB, 5, 0, WORD_W, 8'h00, 0, 3, -1);
        txn(10'h0FF, FRAME_W, 0, WORD_W, 8'h00, 1, 4, -1);
        txn(10'h2F0, 9, 0, WORD_W, 8'h00, 0, 3, -1);
        txn(10'h2A0, FRAME_W, 0, WORD_W, 8'h00, 0, 3, -1);
        txn(10'h3AA, FRAME_W, 1, -1, 8'h00, 0, 3, -1);
        txn(10'h3AB, FRAME_W, 0, 3, 8'h96, 0, 3, -1);
        txn(10'h3AC, FRAME_W, 0, WORD_W, 8'h11, 0, 3, -1);
        txn(10'h2A1, FRAME_W, 0, WORD_W, 8'h00, 0, 3, -1);
        txn(10'h311, FRAME_W, 1, WORD_W, 8'h5A, 0, 3, FRAME_W + 1 + 4);
        txn(10'h3C5, FRAME_W, 0, WORD_W, 8'h00, 1, 3, -1);

        for (int i = 0; i < 60; i++) begin
            logic [FRAME_W-1:0] fr;
            int nb, cut, sel;
            fr  = FRAME_W'($urandom);
            nb  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, FRAME_W - 1)) : FRAME_W;
            sel = int'($urandom_range(0, 5));
            cut = (sel == 0) ? -1 : ((sel == 1) ? int'($urandom_range(0, WORD_W - 1)) : WORD_W);
            txn(fr, nb, int'($urandom_range(0, 3)), cut, WORD_W'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(3, 5)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
